// File: rtl/vector_issue_ctrl.sv
// vector_issue_ctrl: issue/completion controller for the vector lane array.
// Accepts one instruction at a time, broadcasts op/start/scalar/write data to
// all lanes, gathers per-lane done pulses and read beats into a full vector,
// then holds a single response until the sequencer consumes it.
// Optional watchdog: define VECTOR_ISSUE_TIMEOUT_EN to end WAIT after timeout_p
// cycles with resp_err_o=1; otherwise resp_err_o is tied 0.
// Ports:
//   clk_i, reset_n_i                  clock, synchronous active-low reset
//   instr_v_i/instr_ready_o           instruction handshake
//   instr_op_i/scalar_i/w_data_i      instruction fields
//   lane_op_o/scalar_o/w_data_o       registered broadcast, held for the op
//   lane_start_o                      one-cycle start pulse
//   lane_done_i/lane_v_i/lane_r_data_i per-lane completion and read data
//   resp_v_o/resp_yumi_i              response handshake
//   resp_data_o/resp_err_o            gathered vector and timeout flag
module vector_issue_ctrl #(
    parameter int lanes_p    = 4,
    parameter int vlen_p     = 8,
    parameter int vdw_p      = 8,
    parameter int op_width_p = 4,
    parameter int timeout_p  = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     instr_v_i,
    output logic                     instr_ready_o,
    input  logic [op_width_p-1:0]    instr_op_i,
    input  logic [vdw_p-1:0]         instr_scalar_i,
    input  logic [vdw_p-1:0]         instr_w_data_i,
    output logic [op_width_p-1:0]    lane_op_o,
    output logic                     lane_start_o,
    output logic [vdw_p-1:0]         lane_scalar_o,
    output logic [vdw_p-1:0]         lane_w_data_o,
    input  logic [lanes_p-1:0]       lane_done_i,
    input  logic [lanes_p-1:0]       lane_v_i,
    input  logic [lanes_p*vdw_p-1:0] lane_r_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [vlen_p*vdw_p-1:0]  resp_data_o,
    output logic                     resp_err_o
);
    localparam int beats_lp  = vlen_p / lanes_p;
    localparam int beat_w_lp = beats_lp > 1 ? $clog2(beats_lp) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_n;
    logic [lanes_p-1:0]   r_mask;
    logic [beat_w_lp-1:0] r_beat;
    logic                 r_full;
    logic                 w_all_done;
    logic                 w_timeout;
    logic                 w_unused;

    assign instr_ready_o = r_state == IDLE;
    assign lane_start_o  = r_state == ISSUE;
    assign resp_v_o      = r_state == RESP;
    // Include this cycle's pulses so the last done moves to RESP one cycle later.
    assign w_all_done    = &(r_mask | lane_done_i);
    assign w_state_n     = r_state == IDLE  ? (instr_v_i ? ISSUE : IDLE) :
                           r_state == ISSUE ? WAIT :
                           r_state == WAIT  ? (w_all_done || w_timeout ? RESP : WAIT) :
                           (resp_yumi_i ? IDLE : RESP);

`ifdef VECTOR_ISSUE_TIMEOUT_EN
    localparam int tmr_w_lp = $clog2(timeout_p + 1);
    logic [tmr_w_lp-1:0] r_tmr;
    logic                r_err;
    // True on the WAIT cycle where the counter steps up to timeout_p.
    assign w_timeout  = r_tmr == tmr_w_lp'(timeout_p - 1);
    assign resp_err_o = r_err;
    assign w_unused   = ^lane_v_i[lanes_p-1:1];
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_tmr <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmr <= r_state == ISSUE ? '0 : r_state == WAIT ? r_tmr + tmr_w_lp'(1) : r_tmr;
            if (r_state == WAIT && !w_all_done && w_timeout)
                r_err <= 1'b1;
            else if (r_state == RESP && resp_yumi_i)
                r_err <= 1'b0;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign resp_err_o = 1'b0;
    assign w_unused   = ^{lane_v_i[lanes_p-1:1], timeout_p > 0};
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state       <= IDLE;
            r_mask        <= '0;
            r_beat        <= '0;
            r_full        <= 1'b0;
            lane_op_o     <= '0;
            lane_scalar_o <= '0;
            lane_w_data_o <= '0;
            resp_data_o   <= '0;
        end else begin
            r_state <= w_state_n;
            if (instr_v_i && instr_ready_o) begin
                lane_op_o     <= instr_op_i;
                lane_scalar_o <= instr_scalar_i;
                lane_w_data_o <= instr_w_data_i;
            end
            if (r_state == ISSUE) begin
                r_mask <= '0;
                r_beat <= '0;
                r_full <= 1'b0;
            end else if (r_state == WAIT) begin
                r_mask <= r_mask | lane_done_i;
                // Lane 0 valid qualifies the whole beat; beats past the last are dropped.
                if (lane_v_i[0] && !r_full) begin
                    for (int b = 0; b < beats_lp; b++)
                        if (r_beat == beat_w_lp'(b))
                            for (int i = 0; i < lanes_p; i++)
                                resp_data_o[(b*lanes_p+i)*vdw_p +: vdw_p] <= lane_r_data_i[i*vdw_p +: vdw_p];
                    if (r_beat == beat_w_lp'(beats_lp - 1))
                        r_full <= 1'b1;
                    else
                        r_beat <= r_beat + beat_w_lp'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vector_issue_ctrl.sv
// tb_vector_issue_ctrl: randomized scoreboard bench for vector_issue_ctrl.
module tb_vector_issue_ctrl;
    localparam int LANES = 4;
    localparam int VLEN  = 8;
    localparam int VDW   = 8;
    localparam int NEVER = 100000;
`ifdef VECTOR_ISSUE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1000000;
`endif

    typedef struct {
        int                    rcyc;
        logic [VLEN*VDW-1:0]   data;
        bit                    rd;
        bit                    err;
        int                    yd;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset_n_i;
    logic                  instr_v_i;
    logic                  instr_ready_o;
    logic [3:0]            instr_op_i;
    logic [VDW-1:0]        instr_scalar_i;
    logic [VDW-1:0]        instr_w_data_i;
    logic [3:0]            lane_op_o;
    logic                  lane_start_o;
    logic [VDW-1:0]        lane_scalar_o;
    logic [VDW-1:0]        lane_w_data_o;
    logic [LANES-1:0]      lane_done_i;
    logic [LANES-1:0]      lane_v_i;
    logic [LANES*VDW-1:0]  lane_r_data_i;
    logic                  resp_v_o;
    logic                  resp_yumi_i;
    logic [VLEN*VDW-1:0]   resp_data_o;
    logic                  resp_err_o;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   consumed = 0;
    int   last_yumi = -1;
    int   dd[LANES];
    logic [VDW-1:0] vec[VLEN];
    exp_t q[$];

    vector_issue_ctrl #(
        .lanes_p(LANES), .vlen_p(VLEN), .vdw_p(VDW), .op_width_p(4), .timeout_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .instr_v_i(instr_v_i), .instr_ready_o(instr_ready_o),
        .instr_op_i(instr_op_i), .instr_scalar_i(instr_scalar_i), .instr_w_data_i(instr_w_data_i),
        .lane_op_o(lane_op_o), .lane_start_o(lane_start_o),
        .lane_scalar_o(lane_scalar_o), .lane_w_data_o(lane_w_data_o),
        .lane_done_i(lane_done_i), .lane_v_i(lane_v_i), .lane_r_data_i(lane_r_data_i),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 64'(instr_ready_o), 64'd1);
        chk({tag, "_start"}, 64'(lane_start_o), 64'd0);
        chk({tag, "_op"}, 64'(lane_op_o), 64'd0);
        chk({tag, "_scalar"}, 64'(lane_scalar_o), 64'd0);
        chk({tag, "_wdata"}, 64'(lane_w_data_o), 64'd0);
        chk({tag, "_resp_v"}, 64'(resp_v_o), 64'd0);
        chk({tag, "_resp_data"}, resp_data_o, 64'd0);
        chk({tag, "_resp_err"}, 64'(resp_err_o), 64'd0);
    endtask

    task automatic finish_now();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    endtask

    // Lane model: lane i pulses done dd[i] cycles after the start cycle; reads
    // deliver vec over two beats. Expected response = last done + 1, or the
    // watchdog cycle when some lane is later than TO wait cycles.
    task automatic run_op(input logic [3:0] op, input bit spurious, input bit extra,
                          input int yd, input bit hold_v, input bit chk_b2b);
        int   b0, b1, maxd, stop, t, n0, tgt;
        bit   rd;
        logic [VDW-1:0] sc, wd;
        exp_t e;
        rd  = op == 4'b1000;
        sc  = VDW'($urandom);
        wd  = VDW'($urandom);
        b0  = $urandom_range(1, 3);
        b1  = b0 + $urandom_range(1, 3);
        if (rd && dd[0] < b1 + 1) dd[0] = b1 + 1;
        maxd = 0;
        for (int i = 0; i < LANES; i++) if (dd[i] > maxd) maxd = dd[i];
        stop = maxd < TO ? maxd : TO;
        tgt  = consumed + 1;
        e.rd  = rd;
        e.err = maxd > TO;
        e.yd  = yd;
        for (int k = 0; k < VLEN; k++) e.data[k*VDW +: VDW] = vec[k];
        @(negedge clk);
        instr_v_i = 1'b1;
        instr_op_i = op;
        instr_scalar_i = sc;
        instr_w_data_i = wd;
        n0 = 0;
        while (!instr_ready_o) begin
            @(negedge clk);
            if (++n0 > 500) begin
                n_total++;
                $display("FAIL accept_timeout: ready stuck %0d expected 1", instr_ready_o);
                finish_now();
            end
        end
        t = cyc;
        if (chk_b2b) chk("accept_after_yumi", 64'(t), 64'(last_yumi + 1));
        e.rcyc = t + 1 + stop + 1;
        q.push_back(e);
        @(negedge clk);
        instr_v_i = hold_v;
        chk("start_pulse", 64'(lane_start_o), 64'd1);
        chk("start_cycle", 64'(cyc), 64'(t + 1));
        chk("lane_op", 64'(lane_op_o), 64'(op));
        chk("lane_scalar", 64'(lane_scalar_o), 64'(sc));
        chk("lane_wdata", 64'(lane_w_data_o), 64'(wd));
        chk("ready_issue", 64'(instr_ready_o), 64'd0);
        lane_done_i = spurious ? '1 : '0;
        for (int c = 1; c <= stop; c++) begin
            @(negedge clk);
            if (c == 1) chk("start_once", 64'(lane_start_o), 64'd0);
            chk("ready_wait", 64'(instr_ready_o), 64'd0);
            chk("op_hold", 64'({lane_op_o, lane_scalar_o, lane_w_data_o}), 64'({op, sc, wd}));
            for (int i = 0; i < LANES; i++) lane_done_i[i] = dd[i] == c;
            lane_v_i = '0;
            lane_r_data_i = '0;
            if (rd && (c == b0 || c == b1)) begin
                lane_v_i = '1;
                for (int i = 0; i < LANES; i++)
                    lane_r_data_i[i*VDW +: VDW] = vec[i + LANES*(c == b1 ? 1 : 0)];
            end
            if (rd && extra && c == b1 + 1) begin
                lane_v_i = '1;
                lane_r_data_i = $urandom;
            end
        end
        @(negedge clk);
        lane_done_i = '0;
        lane_v_i = '0;
        lane_r_data_i = '0;
        n0 = 0;
        while (consumed < tgt && n0 < 500) begin
            @(consumed or negedge clk);
            n0++;
        end
        if (consumed < tgt) begin
            n_total++;
            $display("FAIL resp_timeout: consumed %0d expected %0d", consumed, tgt);
            finish_now();
        end
    endtask

    // Monitor: pops the scoreboard on the first cycle of each response.
    initial begin
        exp_t cur;
        bit   busy;
        int   wc;
        logic [VLEN*VDW-1:0] snap;
        busy = 0;
        wc = 0;
        snap = '0;
        resp_yumi_i = 1'b0;
        forever begin
            @(negedge clk);
            resp_yumi_i = 1'b0;
            if (reset_n_i !== 1'b1) busy = 0;
            else if (resp_v_o === 1'b1) begin
                if (!busy) begin
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_resp: resp_v 1 expected 0 at cycle %0d", cyc);
                        resp_yumi_i = 1'b1;
                    end else begin
                        cur = q.pop_front();
                        busy = 1;
                        wc = cur.yd;
                        chk("resp_cycle", 64'(cyc), 64'(cur.rcyc));
                        chk("resp_err", 64'(resp_err_o), 64'(cur.err));
                        if (cur.rd && !cur.err) chk("resp_data", resp_data_o, cur.data);
                        snap = resp_data_o;
                    end
                end else begin
                    chk("resp_data_stable", resp_data_o, snap);
                    chk("ready_resp", 64'(instr_ready_o), 64'd0);
                    chk("resp_err_stable", 64'(resp_err_o), 64'(cur.err));
                end
                if (busy) begin
                    if (wc == 0) begin
                        resp_yumi_i = 1'b1;
                        busy = 0;
                        consumed++;
                        last_yumi = cyc;
                    end else wc--;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running");
        $fatal(1);
    end

    initial begin
        reset_n_i = 1'b0;
        instr_v_i = 1'b1;
        instr_op_i = 4'hF;
        instr_scalar_i = 8'hA5;
        instr_w_data_i = 8'h5A;
        lane_done_i = '0;
        lane_v_i = '0;
        lane_r_data_i = '0;
        for (int k = 0; k < VLEN; k++) vec[k] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        instr_v_i = 1'b0;
        reset_n_i = 1'b1;
        @(negedge clk);
        chk("no_accept_in_reset", 64'(lane_start_o), 64'd0);

        // staggered add: done at T+5..T+8, response at T+9
        dd = '{4, 5, 6, 7};
        run_op(4'b0000, 0, 0, 0, 0, 0);
        // read with 8'h10+e over two beats plus an ignored extra beat
        for (int k = 0; k < VLEN; k++) vec[k] = VDW'(8'h10 + k);
        dd = '{4, 5, 6, 7};
        run_op(4'b1000, 0, 1, 0, 0, 1);
        // backpressure: yumi withheld 10 cycles with instr_v held high
        for (int k = 0; k < VLEN; k++) vec[k] = VDW'($urandom);
        dd = '{5, 3, 6, 2};
        run_op(4'b1000, 1, 0, 10, 1, 1);
        // minimum turnaround
        dd = '{1, 1, 1, 1};
        run_op(4'b1111, 0, 0, 0, 0, 1);
        dd = '{1, 1, 1, 1};
        run_op(4'b0000, 1, 0, 0, 0, 1);

        // reset while in WAIT with lanes 0 and 1 already done
        @(negedge clk);
        instr_v_i = 1'b1;
        instr_op_i = 4'b1111;
        @(negedge clk);
        instr_v_i = 1'b0;
        @(negedge clk);
        lane_done_i = 4'b0001;
        @(negedge clk);
        lane_done_i = 4'b0010;
        @(negedge clk);
        lane_done_i = '0;
        reset_n_i = 1'b0;
        @(negedge clk);
        chk_reset_state("midreset");
        reset_n_i = 1'b1;
        dd = '{7, 6, 2, 3};
        run_op(4'b0000, 0, 0, 0, 0, 0);

`ifdef VECTOR_ISSUE_TIMEOUT_EN
        // lane 3 never completes: watchdog response after 16 WAIT cycles
        dd = '{3, 4, 5, NEVER};
        run_op(4'b1000, 0, 0, 2, 0, 1);
        dd = '{2, 2, 2, 2};
        run_op(4'b0000, 0, 0, 0, 0, 1);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            case ($urandom_range(0, 3))
                0: op = 4'b0000;
                1: op = 4'b1000;
                2: op = 4'b1111;
                default: op = 4'($urandom);
            endcase
            for (int k = 0; k < VLEN; k++) vec[k] = VDW'($urandom);
            for (int i = 0; i < LANES; i++) dd[i] = $urandom_range(1, (n % 4 == 3) ? 20 : 12);
            run_op(op, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom), 1);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        finish_now();
    end
endmodule
